// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter that shares one barrel shifter between
// NREQ requesters and returns each result through a one-entry registered
// response stage with backpressure.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_data          operands, requester i at [i*WIDTH +: WIDTH]
//   req_shamt         shift amounts, requester i at [i*5 +: 5]
//   req_type          shift types, requester i at [i*2 +: 2]
//                     (00 LSL, 01 LSR, 10 ASR, 11 reserved)
//   rsp_valid/ready   response handshake
//   rsp_data/id/err   shift result, granted requester, reserved-type flag
//
// Optional build macro SHIFT_ARB_PERF_EN adds perf_grants (accepted
// transfers) and perf_stall (cycles with rsp_valid && !rsp_ready).
module shift_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*5-1:0]     req_shamt,
  input  logic [NREQ*2-1:0]     req_type,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err
`ifdef SHIFT_ARB_PERF_EN
  ,
  output logic [31:0]           perf_grants,
  output logic [31:0]           perf_stall
`endif
);

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_RSV = 2'b11
  } sh_type_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Shared barrel shifter; reserved type passes the operand through.
  function automatic logic [WIDTH-1:0] do_shift(input logic [WIDTH-1:0] d,
                                                input logic [4:0]       sh,
                                                input logic [1:0]       t);
    logic [WIDTH-1:0] r;
    case (sh_type_e'(t))
      SH_LSL:  r = d << sh;
      SH_LSR:  r = d >> sh;
      SH_ASR:  r = $unsigned($signed(d) >>> sh);
      default: r = d;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             err_q, err_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;

  logic             can_accept;
  logic             found;
  logic             xfer;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  int unsigned      idx;

`ifdef SHIFT_ARB_PERF_EN
  logic [31:0] grants_q, grants_d;
  logic [31:0] stall_q, stall_d;
`endif

  // State and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      last_grant_q <= IDW'(NREQ - 1);
`ifdef SHIFT_ARB_PERF_EN
      grants_q     <= '0;
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      id_q         <= id_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
`ifdef SHIFT_ARB_PERF_EN
      grants_q     <= grants_d;
      stall_q      <= stall_d;
`endif
    end
  end

  // Arbitration, handshake and next-state logic.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    id_d         = id_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    found        = 1'b0;
    winner       = last_grant_q;
    cand         = '0;
    idx          = 0;

    can_accept = (state_q == ST_EMPTY) || rsp_ready;

    // Search starts just past the last grant and wraps modulo NREQ.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(last_grant_q) + k) % NREQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    xfer = rst_n && found && can_accept;
    if (xfer) begin
      req_ready[winner] = 1'b1;
    end

    if (xfer) begin
      state_d      = ST_FULL;
      data_d       = do_shift(req_data[winner*WIDTH +: WIDTH],
                              req_shamt[winner*5 +: 5],
                              req_type[winner*2 +: 2]);
      id_d         = winner;
      err_d        = (req_type[winner*2 +: 2] == SH_RSV);
      last_grant_d = winner;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end

`ifdef SHIFT_ARB_PERF_EN
    grants_d = grants_q + 32'(xfer);
    stall_d  = stall_q + 32'((state_q == ST_FULL) && !rsp_ready);
`endif
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

`ifdef SHIFT_ARB_PERF_EN
  assign perf_grants = grants_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_shift_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N*5-1:0] req_shamt;
  logic [N*2-1:0] req_type;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_err;
`ifdef SHIFT_ARB_PERF_EN
  logic [31:0]    perf_grants;
  logic [31:0]    perf_stall;
`endif

  shift_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_type  (req_type),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
`ifdef SHIFT_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_id;
  logic        m_err;
  int          m_last;
  logic [31:0] m_grants;
  logic [31:0] m_stall;
  logic [N-1:0] last_xfer;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          shamt;
    int          typ;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", n, a, e, $time);
    end
  endtask

  // Shift rules expressed with multiplication/division by 2**sh.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input int t);
    longint unsigned p, r;
    p = 1;
    repeat (sh) p = p * 2;
    case (t)
      0: begin r = {32'h0, d} * p; return r[31:0]; end
      1: begin r = {32'h0, d} / p; return r[31:0]; end
      2: begin
        if (d[31]) begin
          r = {32'h0, ~d} / p;
          return ~r[31:0];
        end
        r = {32'h0, d} / p;
        return r[31:0];
      end
      default: return d;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [31:0] d, input int sh, input int t);
    req_data[i*W +: W]  = d;
    req_shamt[i*5 +: 5] = 5'(sh);
    req_type[i*2 +: 2]  = 2'(t);
  endtask

  // One clock: check combinational ready, advance model, check registered outputs.
  task automatic cycle();
    logic [N-1:0] er;
    int           w;
    logic [31:0]  nd;
    logic         ne;
    logic         was_stall;
    #1;
    er = '0;
    w  = -1;
    nd = '0;
    ne = 1'b0;
    if (rst_n === 1'b1) begin
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
      end
      if (w >= 0 && (!m_valid || rsp_ready)) er[w] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    if (w >= 0) begin
      nd = ref_shift(req_data[w*W +: W], int'(req_shamt[w*5 +: 5]), int'(req_type[w*2 +: 2]));
      ne = (req_type[w*2 +: 2] == 2'b11);
    end
    was_stall = m_valid && !rsp_ready;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_last = N - 1;
      m_grants = '0; m_stall = '0;
    end else begin
      if (was_stall) m_stall = m_stall + 1;
      if (er != '0) begin
        m_valid = 1'b1; m_data = nd; m_id = w; m_err = ne; m_last = w;
        m_grants = m_grants + 1;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    last_xfer = er;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_err", 32'(rsp_err), 32'(m_err));
`ifdef SHIFT_ARB_PERF_EN
    chk("perf_grants", perf_grants, m_grants);
    chk("perf_stall", perf_stall, m_stall);
`endif
  endtask

  initial begin
    vecs[0] = '{0, 32'h80000001, 4,  2, 32'hF8000000, 1'b0};
    vecs[1] = '{1, 32'hFFFFFFFF, 31, 1, 32'h00000001, 1'b0};
    vecs[2] = '{2, 32'h12345678, 0,  0, 32'h12345678, 1'b0};
    vecs[3] = '{3, 32'hDEADBEEF, 8,  3, 32'hDEADBEEF, 1'b1};
    vecs[4] = '{0, 32'h7FFFFFFF, 31, 2, 32'h00000000, 1'b0};
    vecs[5] = '{1, 32'h00000001, 31, 0, 32'h80000000, 1'b0};
    vecs[6] = '{2, 32'h80000000, 31, 2, 32'hFFFFFFFF, 1'b0};

    m_valid = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_last = N - 1;
    m_grants = '0; m_stall = '0; last_xfer = '0;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_shamt = '0; req_type = '0;
    rsp_ready = 1'b1;

    // Reset then idle
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_data", rsp_data, 32'd0);

    // Single ASR request on requester 0
    set_req(0, 32'h80000001, 4, 2);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_data", rsp_data, 32'hF8000000);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_err", 32'(rsp_err), 32'd0);
    cycle();

    // Round robin from a fresh reset
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 1, 0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_data", rsp_data, 32'(2 * (k % 4 + 1)));
    end

    // Backpressure while holding the id-0 response
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    set_req(1, 32'h0000F000, 4, 1);
    set_req(2, 32'h0000000F, 4, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_data", rsp_data, 32'd2);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_rel_id", 32'(rsp_id), 32'd1);
    chk("bp_rel_data", rsp_data, 32'h00000F00);
    req_valid = 4'b0100;
    cycle();
    chk("bp_next_id", 32'(rsp_id), 32'd2);
    chk("bp_next_data", rsp_data, 32'h000000F0);
    req_valid = '0;
    cycle();

    // Boundary table
    foreach (vecs[j]) begin
      set_req(vecs[j].id, vecs[j].data, vecs[j].shamt, vecs[j].typ);
      req_valid = '0;
      req_valid[vecs[j].id] = 1'b1;
      cycle();
      req_valid = '0;
      chk("tbl_data", rsp_data, vecs[j].exp_data);
      chk("tbl_err", 32'(rsp_err), 32'(vecs[j].exp_err));
      chk("tbl_id", 32'(rsp_id), 32'(vecs[j].id));
    end
    cycle();

    // Reset while a response is held under backpressure
    set_req(3, 32'h00000010, 1, 1);
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    rsp_ready = 1'b0;
    cycle();
    chk("mid_held", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
`ifdef SHIFT_ARB_PERF_EN
    chk("mid_rst_grants", perf_grants, 32'd0);
`endif
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    cycle();
    chk("mid_first_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    cycle();

    // Randomized traffic; unaccepted requests hold their fields
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_xfer[i])) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          set_req(i, $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
